// File: rtl/core_if.sv
// Memory bus between the core pipeline and its unified byte-addressed memory.
// Fetch and data ports are independent; writes are byte-enabled from daddr upward.
interface core_if;
    logic [15:0] iaddr;
    logic [31:0] idata;
    logic [15:0] daddr;
    logic [31:0] drdata;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;

    modport master (output iaddr, daddr, dwdata, dstrb, input idata, drdata);
    modport slave  (input iaddr, daddr, dwdata, dstrb, output idata, drdata);
endinterface

// File: rtl/core.sv
// Five-stage in-order RV32I core with machine-mode CSRs and a unified 64 KiB memory.
// Only clk/rst are ports; program, registers and CSRs are reached hierarchically.
module core_mem (
    input logic   clk,
    core_if.slave bus
);
    logic [7:0] m [0:65535];

    // Each byte address wraps independently, so misaligned words simply straddle the wrap.
    assign bus.idata  = {m[bus.iaddr + 16'd3], m[bus.iaddr + 16'd2], m[bus.iaddr + 16'd1], m[bus.iaddr]};
    assign bus.drdata = {m[bus.daddr + 16'd3], m[bus.daddr + 16'd2], m[bus.daddr + 16'd1], m[bus.daddr]};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus.dstrb[i]) m[bus.daddr + 16'(i)] <= bus.dwdata[8*i +: 8];
    end
endmodule

module core (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67,
                           OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                           OP_IMM = 7'h13, OP_OP = 7'h33, OP_SYSTEM = 7'h73;

    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];
    logic [31:0] if_pc;

    core_if bus ();
    core_mem memory (.clk(clk), .bus(bus));

    logic        id_valid, ex_valid, mem_we, mem_load, wb_we;
    logic [31:0] id_pc, id_instr, ex_pc, ex_instr, ex_a, ex_b;
    logic [4:0]  mem_rd, wb_rd;
    logic [2:0]  mem_f3;
    logic [3:0]  mem_strb;
    logic [31:0] mem_result, mem_wdata, mem_value, wb_result, load_ext;

    logic [6:0]  id_op, ex_op;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_f3;
    logic        id_use1, id_use2, stall;
    logic [31:0] id_a, id_b;

    assign id_op   = id_instr[6:0];
    assign id_rs1  = id_instr[19:15];
    assign id_rs2  = id_instr[24:20];
    assign id_use1 = !(id_op == OP_LUI || id_op == OP_AUIPC || id_op == OP_JAL);
    assign id_use2 = id_op == OP_BRANCH || id_op == OP_STORE || id_op == OP_OP;
    // wb_we is never set for x0, so the bypass cannot leak a value into register 0.
    assign id_a    = (wb_we && wb_rd == id_rs1) ? wb_result : rs[id_rs1];
    assign id_b    = (wb_we && wb_rd == id_rs2) ? wb_result : rs[id_rs2];

    assign ex_op  = ex_instr[6:0];
    assign ex_f3  = ex_instr[14:12];
    assign ex_rd  = ex_instr[11:7];
    assign ex_rs1 = ex_instr[19:15];
    assign ex_rs2 = ex_instr[24:20];
    assign stall  = ex_valid && ex_op == OP_LOAD && ex_rd != 5'd0 && id_valid &&
                    ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};
    assign imm_s = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
    assign imm_b = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7], ex_instr[30:25], ex_instr[11:8], 1'b0};
    assign imm_u = {ex_instr[31:12], 12'h000};
    assign imm_j = {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12], ex_instr[20], ex_instr[30:21], 1'b0};

    // MEM is checked before WB so the younger producer wins.
    logic [31:0] op_a, op_b, alu_b, alu;
    logic signed [31:0] sra;
    assign op_a  = (mem_we && mem_rd == ex_rs1) ? mem_value : (wb_we && wb_rd == ex_rs1) ? wb_result : ex_a;
    assign op_b  = (mem_we && mem_rd == ex_rs2) ? mem_value : (wb_we && wb_rd == ex_rs2) ? wb_result : ex_b;
    assign alu_b = (ex_op == OP_OP) ? op_b : imm_i;
    assign sra   = $signed(op_a) >>> alu_b[4:0];

    logic [11:0] csr_addr;
    logic [31:0] csr_old, csr_src, csr_new;
    logic        is_csr, is_ecall, is_mret;
    assign csr_addr = ex_instr[31:20];
    assign csr_old  = (csr_addr == 12'hF14) ? 32'h0 : csr[csr_addr];
    assign csr_src  = ex_f3[2] ? {27'h0, ex_rs1} : op_a;
    assign is_csr   = ex_op == OP_SYSTEM && ex_f3 != 3'b000;
    assign is_ecall = ex_instr == 32'h0000_0073;
    assign is_mret  = ex_instr == 32'h3020_0073;

    always_comb begin
        case (ex_f3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_old | csr_src;
            default: csr_new = csr_old & ~csr_src;
        endcase
    end

    always_comb begin
        case (ex_f3)
            3'b000:  alu = (ex_op == OP_OP && ex_instr[30]) ? op_a - alu_b : op_a + alu_b;
            3'b001:  alu = op_a << alu_b[4:0];
            3'b010:  alu = {31'h0, $signed(op_a) < $signed(alu_b)};
            3'b011:  alu = {31'h0, op_a < alu_b};
            3'b100:  alu = op_a ^ alu_b;
            3'b101:  alu = ex_instr[30] ? sra : op_a >> alu_b[4:0];
            3'b110:  alu = op_a | alu_b;
            default: alu = op_a & alu_b;
        endcase
    end

    // Control transfers all resolve here; a taken redirect squashes IF and ID.
    logic        taken, reg_we;
    logic [31:0] target, result;
    always_comb begin
        taken  = 1'b0;
        reg_we = 1'b0;
        target = ex_pc + imm_b;
        result = alu;
        case (ex_op)
            OP_LUI:   begin result = imm_u; reg_we = 1'b1; end
            OP_AUIPC: begin result = ex_pc + imm_u; reg_we = 1'b1; end
            OP_JAL:   begin result = ex_pc + 32'd4; reg_we = 1'b1; taken = 1'b1; target = ex_pc + imm_j; end
            OP_JALR:  begin result = ex_pc + 32'd4; reg_we = 1'b1; taken = 1'b1; target = (op_a + imm_i) & ~32'd1; end
            OP_BRANCH: begin
                case (ex_f3)
                    3'b000:  taken = op_a == op_b;
                    3'b001:  taken = op_a != op_b;
                    3'b100:  taken = $signed(op_a) < $signed(op_b);
                    3'b101:  taken = $signed(op_a) >= $signed(op_b);
                    3'b110:  taken = op_a < op_b;
                    3'b111:  taken = op_a >= op_b;
                    default: taken = 1'b0;
                endcase
            end
            OP_LOAD:  begin result = op_a + imm_i; reg_we = 1'b1; end
            OP_STORE: result = op_a + imm_s;
            OP_IMM, OP_OP: reg_we = 1'b1;
            OP_SYSTEM: begin
                if (is_csr) begin
                    result = csr_old;
                    reg_we = 1'b1;
                end else if (is_ecall) begin
                    taken  = 1'b1;
                    target = {csr[12'h305][31:2], 2'b00};
                end else if (is_mret) begin
                    taken  = 1'b1;
                    target = csr[12'h341];
                end
            end
            default: ;
        endcase
        if (!ex_valid) taken = 1'b0;
        if (!ex_valid || ex_rd == 5'd0) reg_we = 1'b0;
    end

    always_comb begin
        case (mem_f3)
            3'b000:  load_ext = {{24{bus.drdata[7]}}, bus.drdata[7:0]};
            3'b001:  load_ext = {{16{bus.drdata[15]}}, bus.drdata[15:0]};
            3'b100:  load_ext = {24'h0, bus.drdata[7:0]};
            3'b101:  load_ext = {16'h0, bus.drdata[15:0]};
            default: load_ext = bus.drdata;
        endcase
        mem_value = mem_load ? load_ext : mem_result;
    end

    assign bus.iaddr  = if_pc[15:0];
    assign bus.daddr  = mem_result[15:0];
    assign bus.dwdata = mem_wdata;
    assign bus.dstrb  = mem_strb;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc    <= 32'h0;
            id_valid <= 1'b0;
            ex_valid <= 1'b0;
            mem_we   <= 1'b0;
            mem_load <= 1'b0;
            mem_strb <= 4'h0;
            wb_we    <= 1'b0;
        end else begin
            if (taken) begin
                if_pc    <= target;
                id_valid <= 1'b0;
            end else if (!stall) begin
                if_pc    <= if_pc + 32'd4;
                id_valid <= 1'b1;
                id_pc    <= if_pc;
                id_instr <= bus.idata;
            end
            ex_valid   <= id_valid && !taken && !stall;
            ex_pc      <= id_pc;
            ex_instr   <= id_instr;
            ex_a       <= id_a;
            ex_b       <= id_b;
            mem_we     <= reg_we;
            mem_rd     <= ex_rd;
            mem_load   <= ex_valid && ex_op == OP_LOAD;
            mem_f3     <= ex_f3;
            mem_result <= result;
            mem_wdata  <= op_b;
            mem_strb   <= (ex_valid && ex_op == OP_STORE) ?
                          (ex_f3[1] ? 4'hF : (ex_f3[0] ? 4'h3 : 4'h1)) : 4'h0;
            wb_we      <= mem_we;
            wb_rd      <= mem_rd;
            wb_result  <= mem_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rs[i] <= 32'h0;
        end else if (wb_we) begin
            rs[wb_rd] <= wb_result;
        end
    end

    // CSR writes land at the end of EX, so the next instruction in EX already sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) csr[i] <= 32'h0;
        end else if (ex_valid && ex_op == OP_SYSTEM) begin
            if (is_csr && csr_addr != 12'hF14) begin
                csr[csr_addr] <= csr_new;
            end else if (is_ecall) begin
                csr[12'h341] <= ex_pc;
                csr[12'h342] <= 32'd11;
            end
        end
    end
endmodule

// File: tb/tb_core.sv
// Directed machine-code programs for core; expectations are queued when a program is
// issued and a separate monitor compares them once the program reaches its halt loop.
module tb_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core dut (.clk(clk), .rst(rst));

    typedef enum int {K_RS, K_CSR, K_MEM, K_PC, K_OBS} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        int          idx;
        logic [31:0] value;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs [0:3];
    int          vectors = 0;
    int          miscompares = 0;
    event        present;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) dut.memory.m[16'(addr + i)] = w[8*i +: 8];
    endtask

    task automatic expect_val(input string name, input kind_t kind, input int idx, input logic [31:0] v);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.idx   = idx;
        e.value = v;
        exp_q.push_back(e);
    endtask

    task automatic begin_prog();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 512; a++) dut.memory.m[16'(a)] = 8'h00;
    endtask

    task automatic present_now();
        ->present;
        #1;
    endtask

    // Release reset, run until fetch reaches the halt loop, then let the tail drain.
    task automatic apply_stimulus(input logic [31:0] halt, input logic [31:0] watch, input int budget);
        int c = 0;
        int seen = -1;
        bit hit = 1'b0;
        obs[0] = 32'h0;
        obs[1] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        while (c < budget && !hit) begin
            @(negedge clk);
            c++;
            if (seen < 0 && dut.if_pc == watch) seen = c;
            if (seen >= 0 && c == seen + 3) obs[1] = dut.if_pc;
            if (dut.if_pc == halt) hit = 1'b1;
        end
        obs[0] = 32'(c);
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL halt_timeout: if_pc %h, expected %h within %0d cycles", dut.if_pc, halt, budget);
        end
        repeat (8) @(negedge clk);
        present_now();
    endtask

    task automatic check_output();
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_RS:    act = dut.rs[e.idx];
                K_CSR:   act = dut.csr[e.idx];
                K_MEM:   act = {24'h0, dut.memory.m[e.idx]};
                K_PC:    act = dut.if_pc;
                default: act = obs[e.idx];
            endcase
            vectors++;
            if (act !== e.value) begin
                miscompares++;
                $display("[TB] FAIL %s: got %h, expected %h", e.name, act, e.value);
            end
        end
    endtask

    initial begin
        forever begin
            @(present);
            check_output();
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state, then forwarding without stalls.
        begin_prog();
        expect_val("reset_pc", K_PC, 0, 32'h0);
        expect_val("reset_x1", K_RS, 1, 32'h0);
        expect_val("reset_mtvec", K_CSR, 12'h305, 32'h0);
        present_now();
        put(0,  enc_i(12'd5, 0, 3'b000, 1, 7'h13));
        put(4,  enc_i(12'd3, 1, 3'b000, 2, 7'h13));
        put(8,  enc_r(7'h00, 2, 1, 3'b000, 3));
        put(12, enc_j(21'h0, 0));
        expect_val("fwd_x1", K_RS, 1, 32'd5);
        expect_val("fwd_x2", K_RS, 2, 32'd8);
        expect_val("fwd_x3", K_RS, 3, 32'd13);
        expect_val("fwd_cycles", K_OBS, 0, 32'd3);
        apply_stimulus(32'd12, 32'hFFFF_FFFF, 200);

        // Stores, loads, extension and the load-use stall.
        begin_prog();
        put(0,  enc_u(20'h12345, 1, 7'h37));
        put(4,  enc_i(12'h678, 1, 3'b000, 1, 7'h13));
        put(8,  enc_s(12'h100, 1, 0, 3'b010));
        put(12, enc_i(12'h100, 0, 3'b010, 2, 7'h03));
        put(16, enc_i(12'd1, 2, 3'b000, 3, 7'h13));
        put(20, enc_i(12'h103, 0, 3'b000, 4, 7'h03));
        put(24, enc_i(12'h080, 0, 3'b000, 5, 7'h13));
        put(28, enc_s(12'h111, 5, 0, 3'b000));
        put(32, enc_i(12'h110, 0, 3'b001, 6, 7'h03));
        put(36, enc_i(12'h110, 0, 3'b101, 8, 7'h03));
        put(40, enc_i(12'h111, 0, 3'b100, 7, 7'h03));
        put(44, enc_j(21'h0, 0));
        expect_val("lw_x2", K_RS, 2, 32'h1234_5678);
        expect_val("lu_x3", K_RS, 3, 32'h1234_5679);
        expect_val("lb_x4", K_RS, 4, 32'h0000_0012);
        expect_val("lh_x6", K_RS, 6, 32'hFFFF_8000);
        expect_val("lbu_x7", K_RS, 7, 32'h0000_0080);
        expect_val("lhu_x8", K_RS, 8, 32'h0000_8000);
        expect_val("sw_byte0", K_MEM, 16'h100, 32'h78);
        expect_val("sw_byte3", K_MEM, 16'h103, 32'h12);
        expect_val("sb_neighbor", K_MEM, 16'h112, 32'h00);
        expect_val("stall_cycles", K_OBS, 0, 32'd12);
        apply_stimulus(32'd44, 32'hFFFF_FFFF, 200);

        // Taken branch flushes the shadow.
        begin_prog();
        put(0,  enc_i(12'd1, 0, 3'b000, 1, 7'h13));
        put(4,  enc_b(13'd12, 0, 0, 3'b000));
        put(8,  enc_i(12'd7, 0, 3'b000, 5, 7'h13));
        put(12, enc_i(12'd1, 5, 3'b000, 5, 7'h13));
        put(16, enc_i(12'd9, 0, 3'b000, 6, 7'h13));
        put(20, enc_j(21'h0, 0));
        expect_val("beq_taken_x5", K_RS, 5, 32'd0);
        expect_val("beq_taken_x6", K_RS, 6, 32'd9);
        apply_stimulus(32'd20, 32'hFFFF_FFFF, 200);

        // Not-taken branch, JAL and JALR with link values.
        begin_prog();
        put(0,  enc_i(12'd1, 0, 3'b000, 1, 7'h13));
        put(4,  enc_b(13'd12, 0, 1, 3'b000));
        put(8,  enc_i(12'd7, 0, 3'b000, 5, 7'h13));
        put(12, enc_i(12'd1, 5, 3'b000, 5, 7'h13));
        put(16, enc_j(21'd8, 10));
        put(20, enc_i(12'd1, 0, 3'b000, 6, 7'h13));
        put(24, enc_i(12'd37, 0, 3'b000, 11, 7'h67));
        put(28, enc_i(12'd2, 0, 3'b000, 6, 7'h13));
        put(32, enc_i(12'd3, 0, 3'b000, 6, 7'h13));
        put(36, enc_i(12'd4, 0, 3'b000, 7, 7'h13));
        put(40, enc_j(21'h0, 0));
        expect_val("beq_nt_x5", K_RS, 5, 32'd8);
        expect_val("jump_flush_x6", K_RS, 6, 32'd0);
        expect_val("jal_link", K_RS, 10, 32'd20);
        expect_val("jalr_link", K_RS, 11, 32'd28);
        expect_val("jalr_target_x7", K_RS, 7, 32'd4);
        apply_stimulus(32'd40, 32'hFFFF_FFFF, 200);

        // Compares, shifts, subtraction and the x0 sink.
        begin_prog();
        put(0,  enc_i(12'hFFE, 0, 3'b000, 1, 7'h13));
        put(4,  enc_i(12'hFFF, 1, 3'b010, 3, 7'h13));
        put(8,  enc_i(12'hFFF, 0, 3'b011, 4, 7'h13));
        put(12, enc_u(20'h80000, 5, 7'h37));
        put(16, enc_i(12'h41F, 5, 3'b101, 6, 7'h13));
        put(20, enc_i(12'h01F, 5, 3'b101, 7, 7'h13));
        put(24, enc_r(7'h20, 1, 0, 3'b000, 8));
        put(28, enc_r(7'h00, 0, 1, 3'b011, 9));
        put(32, enc_r(7'h00, 0, 1, 3'b010, 12));
        put(36, enc_i(12'd33, 0, 3'b000, 13, 7'h13));
        put(40, enc_r(7'h00, 13, 1, 3'b001, 14));
        put(44, enc_i(12'd5, 0, 3'b000, 0, 7'h13));
        put(48, enc_j(21'h0, 0));
        expect_val("slti", K_RS, 3, 32'd1);
        expect_val("sltiu", K_RS, 4, 32'd1);
        expect_val("srai", K_RS, 6, 32'hFFFF_FFFF);
        expect_val("srli", K_RS, 7, 32'd1);
        expect_val("sub", K_RS, 8, 32'd2);
        expect_val("sltu", K_RS, 9, 32'd0);
        expect_val("slt", K_RS, 12, 32'd1);
        expect_val("sll_low5", K_RS, 14, 32'hFFFF_FFFC);
        expect_val("x0_zero", K_RS, 0, 32'd0);
        apply_stimulus(32'd48, 32'hFFFF_FFFF, 200);

        // ECALL into a handler that MRETs back once, then leaves on the second entry.
        begin_prog();
        put(32'h00, enc_i(12'd1, 10, 3'b000, 10, 7'h13));
        put(32'h04, enc_i(12'h040, 0, 3'b000, 1, 7'h13));
        put(32'h08, enc_i(12'h305, 1, 3'b001, 0, 7'h73));
        put(32'h0C, enc_j(21'd20, 0));
        put(32'h20, 32'h0000_0073);
        put(32'h24, enc_i(12'd1, 0, 3'b000, 5, 7'h13));
        put(32'h40, enc_i(12'h341, 0, 3'b010, 6, 7'h73));
        put(32'h44, enc_i(12'h342, 0, 3'b010, 7, 7'h73));
        put(32'h48, enc_i(12'd1, 8, 3'b000, 8, 7'h13));
        put(32'h4C, enc_i(12'd2, 0, 3'b000, 9, 7'h13));
        put(32'h50, enc_b(13'h030, 9, 8, 3'b000));
        put(32'h54, 32'h3020_0073);
        put(32'h80, enc_j(21'h0, 0));
        expect_val("ecall_next_pc", K_OBS, 1, 32'h40);
        expect_val("mepc", K_CSR, 12'h341, 32'h20);
        expect_val("mcause", K_CSR, 12'h342, 32'd11);
        expect_val("mtvec", K_CSR, 12'h305, 32'h40);
        expect_val("handler_mepc", K_RS, 6, 32'h20);
        expect_val("handler_mcause", K_RS, 7, 32'd11);
        expect_val("mret_reentries", K_RS, 8, 32'd2);
        expect_val("ecall_shadow_x5", K_RS, 5, 32'd0);
        expect_val("no_restart_x10", K_RS, 10, 32'd1);
        apply_stimulus(32'h80, 32'h20, 300);

        // CSR register and immediate forms, back-to-back, and the read-only hart id.
        begin_prog();
        put(0,  enc_i(12'h00F, 0, 3'b000, 1, 7'h13));
        put(4,  enc_i(12'h300, 1, 3'b001, 2, 7'h73));
        put(8,  enc_i(12'h300, 0, 3'b010, 3, 7'h73));
        put(12, enc_i(12'h300, 3, 3'b111, 4, 7'h73));
        put(16, enc_i(12'h300, 16, 3'b110, 5, 7'h73));
        put(20, enc_i(12'hF14, 7, 3'b101, 6, 7'h73));
        put(24, enc_i(12'hF14, 0, 3'b010, 7, 7'h73));
        put(28, 32'h0000_000F);
        put(32, enc_j(21'h0, 0));
        expect_val("csrrw_old", K_RS, 2, 32'h0);
        expect_val("csr_raw_fwd", K_RS, 3, 32'hF);
        expect_val("csrrci_old", K_RS, 4, 32'hF);
        expect_val("csrrsi_old", K_RS, 5, 32'hC);
        expect_val("mhartid_rw", K_RS, 6, 32'h0);
        expect_val("mhartid_rs", K_RS, 7, 32'h0);
        expect_val("csr300_final", K_CSR, 12'h300, 32'h1C);
        apply_stimulus(32'd32, 32'hFFFF_FFFF, 200);

        // Reset clears registers and CSRs but leaves memory alone.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_val("rst_pc", K_PC, 0, 32'h0);
        expect_val("rst_x3", K_RS, 3, 32'h0);
        expect_val("rst_csr300", K_CSR, 12'h300, 32'h0);
        expect_val("rst_mem_kept", K_MEM, 0, 32'h93);
        present_now();

        // Reset in the middle of a running loop aborts it and restarts fetch at 0.
        begin_prog();
        put(0, enc_i(12'd1, 1, 3'b000, 1, 7'h13));
        put(4, enc_j(21'h1FFFFC, 0));
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_val("midrst_pc", K_PC, 0, 32'h0);
        expect_val("midrst_x1", K_RS, 1, 32'h0);
        present_now();
        rst = 1'b0;
        @(negedge clk);
        obs[2] = dut.if_pc;
        expect_val("restart_pc", K_OBS, 2, 32'h4);
        expect_val("restart_x1", K_RS, 1, 32'h0);
        present_now();

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
